// File: rtl/sp_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ram_pkg
//  Description : Shared types, limits and helpers for the sp_ram_model
//                behavioural single-port SRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
package sp_ram_pkg;

    // Controller states: clearing/initialising, then serving accesses
    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } sp_ram_state_e;

    // Deepest supported read pipeline
    localparam int MAX_READ_LATENCY = 4;

    // Even-parity bit for one byte: makes the 9-bit group have an even count of ones
    function automatic logic byte_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage : sp_ram_pkg
`default_nettype wire

// File: rtl/sp_ram_rd_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ram_rd_pipe
//  Description : Fixed-depth delay line carrying {valid, data, oob, perr}
//                from the acceptance edge to the read response.
//  Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_rd_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_oob,
    input  logic             i_perr,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_oob,
    output logic             o_perr
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_oob;
    logic [DEPTH-1:0] r_perr;
    logic [WIDTH-1:0] r_data [DEPTH];

    // Advance every entry one stage per cycle; reset flushes all in-flight entries
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_oob   <= '0;
            r_perr  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_oob[0]   <= i_oob;
            r_perr[0]  <= i_perr;
            r_data[0]  <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_oob[i]   <= r_oob[i-1];
                r_perr[i]  <= r_perr[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_oob   = r_oob[DEPTH-1];
    assign o_perr  = r_perr[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];

endmodule : sp_ram_rd_pipe
`default_nettype wire

// File: rtl/sp_ram_model.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ram_model
//  Description : Behavioural single-port SRAM stand-in for library macros.
//                Byte-enable writes, READ_LATENCY-deep read pipeline,
//                optional post-reset clear sweep, out-of-range flagging.
//                Optional per-byte even parity: define SP_RAM_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_model
    import sp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_WORDS      = 256,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    output logic                    gnt_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    rvalid_o,
    output logic                    oob_err_o,
    output logic                    parity_err_o,
    output logic                    init_done_o
);

    localparam int c_nb    = DATA_WIDTH / 8;
    localparam int c_idx_w = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int c_depth = (READ_LATENCY < 1) ? 1 :
                             (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;
    localparam bit c_clear = (CLEAR_ON_RESET != 0);
    localparam logic [c_idx_w-1:0]  c_last_idx  = c_idx_w'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH:0] c_num_words = (ADDR_WIDTH + 1)'(NUM_WORDS);

    sp_ram_state_e           r_state;
    sp_ram_state_e           w_state_nxt;
    logic [c_idx_w-1:0]      r_clr_cnt;
    logic [c_idx_w-1:0]      w_idx;
    logic                    w_in_range;
    logic                    w_acc;
    logic                    w_wr;
    logic                    w_clear_wr;
    logic                    w_par_mis;
    logic [DATA_WIDTH-1:0]   w_rd_word;
    logic [DATA_WIDTH-1:0]   r_rdata_hold;
    logic [DATA_WIDTH-1:0]   w_pipe_data;
    logic                    w_pipe_valid;

    logic [DATA_WIDTH-1:0]   r_mem [NUM_WORDS];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave init after the last word is cleared, or at once if no sweep
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:  if (!c_clear || (r_clr_cnt == c_last_idx)) w_state_nxt = S_READY;
            S_READY: w_state_nxt = S_READY;
            default: w_state_nxt = S_INIT;
        endcase
    end

    // State outputs: no back-pressure once ready, nothing granted during init
    always_comb begin
        gnt_o       = 1'b0;
        init_done_o = 1'b0;
        if (r_state == S_READY) begin
            gnt_o       = en_i;
            init_done_o = 1'b1;
        end
    end

    // Clear sweep pointer, restarts from word 0 on every reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_cnt <= '0;
        end else if ((r_state == S_INIT) && c_clear) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    // Range check happens on the full address so high addresses never alias
    assign w_in_range = ({1'b0, addr_i} < c_num_words);
    assign w_idx      = addr_i[c_idx_w-1:0];
    assign w_acc      = en_i & gnt_o & ~rst;
    assign w_wr       = w_acc & we_i & w_in_range;
    assign w_clear_wr = (r_state == S_INIT) && c_clear && !rst;
    assign w_rd_word  = r_mem[w_idx];

    // Storage: sweep zeroes one word per cycle, otherwise byte-enabled writes
    always_ff @(posedge clk) begin
        if (w_clear_wr) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr) begin
            for (int b = 0; b < c_nb; b++) begin
                if (be_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

`ifdef SP_RAM_PARITY_EN
    logic [c_nb-1:0] r_par [NUM_WORDS];

    // Parity bits follow their bytes; the sweep leaves them at 0 like the data
    always_ff @(posedge clk) begin
        if (w_clear_wr) begin
            r_par[r_clr_cnt] <= '0;
        end else if (w_wr) begin
            for (int b = 0; b < c_nb; b++) begin
                if (be_i[b]) begin
                    r_par[w_idx][b] <= byte_parity(wdata_i[8*b +: 8]);
                end
            end
        end
    end

    // Recompute parity of the addressed word and compare with the stored bits
    always_comb begin
        w_par_mis = 1'b0;
        for (int b = 0; b < c_nb; b++) begin
            w_par_mis = w_par_mis | (byte_parity(w_rd_word[8*b +: 8]) != r_par[w_idx][b]);
        end
    end
`else
    assign w_par_mis = 1'b0;
`endif

    sp_ram_rd_pipe #(
        .DEPTH (c_depth),
        .WIDTH (DATA_WIDTH)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_acc & ~we_i),
        .i_data  (w_in_range ? w_rd_word : '0),
        .i_oob   (w_acc & ~w_in_range),
        .i_perr  (w_acc & ~we_i & w_in_range & w_par_mis),
        .o_valid (w_pipe_valid),
        .o_data  (w_pipe_data),
        .o_oob   (oob_err_o),
        .o_perr  (parity_err_o)
    );

    // Keep the last returned word so rdata_o only moves together with rvalid_o
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata_hold <= '0;
        end else if (w_pipe_valid) begin
            r_rdata_hold <= w_pipe_data;
        end
    end

    assign rvalid_o = w_pipe_valid;
    assign rdata_o  = w_pipe_valid ? w_pipe_data : r_rdata_hold;

endmodule : sp_ram_model
`default_nettype wire

// File: tb/tb_sp_ram_model.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sp_ram_model
//  Description : Directed self-checking bench. Instance A: 256 words,
//                latency 1, clear sweep. Instance B: 200 words, latency 3,
//                no clear sweep. Parity scenario active with SP_RAM_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_ram_model;

    logic        clk;
    logic        a_rst, a_en, a_we;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_be;
    logic        a_gnt, a_rvalid, a_oob, a_perr, a_done;
    logic [31:0] a_rdata;

    logic        b_rst, b_en, b_we;
    logic [7:0]  b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_be;
    logic        b_gnt, b_rvalid, b_oob, b_perr, b_done;
    logic [31:0] b_rdata;

    int vectors    = 0;
    int miscompares = 0;

    sp_ram_model #(
        .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_WORDS(256), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clk(clk), .rst(a_rst), .en_i(a_en), .we_i(a_we), .addr_i(a_addr), .wdata_i(a_wdata),
        .be_i(a_be), .gnt_o(a_gnt), .rdata_o(a_rdata), .rvalid_o(a_rvalid), .oob_err_o(a_oob),
        .parity_err_o(a_perr), .init_done_o(a_done)
    );

    sp_ram_model #(
        .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_WORDS(200), .READ_LATENCY(3), .CLEAR_ON_RESET(0)
    ) dut_b (
        .clk(clk), .rst(b_rst), .en_i(b_en), .we_i(b_we), .addr_i(b_addr), .wdata_i(b_wdata),
        .be_i(b_be), .gnt_o(b_gnt), .rdata_o(b_rdata), .rvalid_o(b_rvalid), .oob_err_o(b_oob),
        .parity_err_o(b_perr), .init_done_o(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access on A; returns at posedge+1 after the acceptance edge
    task automatic a_issue(input logic we, input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] be);
        a_en = 1'b1; a_we = we; a_addr = addr; a_wdata = data; a_be = be;
        @(posedge clk); #1;
        a_en = 1'b0; a_we = 1'b0;
    endtask

    // One access on B; returns at posedge+1 after the acceptance edge
    task automatic b_issue(input logic we, input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] be);
        b_en = 1'b1; b_we = we; b_addr = addr; b_wdata = data; b_be = be;
        @(posedge clk); #1;
        b_en = 1'b0; b_we = 1'b0;
    endtask

    // Watch B for 5 cycles after an acceptance (k=1 is the cycle right after it)
    task automatic b_observe(output int rv_n, output int rv_pos, output int oob_n,
                             output int oob_pos, output int perr_n, output logic [31:0] rd);
        rv_n = 0; rv_pos = 0; oob_n = 0; oob_pos = 0; perr_n = 0; rd = 32'h0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (b_rvalid) begin rv_n++; rv_pos = k; rd = b_rdata; end
            if (b_oob) begin oob_n++; oob_pos = k; end
            if (b_perr) perr_n++;
        end
    endtask

    task automatic test_reset;
        int  cycles;
        bit  saw_rv, saw_gnt;
        a_rst = 1'b1; a_en = 1'b1; a_we = 1'b0; a_addr = 8'h10;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (a_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid: got %b expected 0", a_rvalid); end
        vectors++; if (a_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h expected 00000000", a_rdata); end
        vectors++; if (a_oob !== 1'b0) begin miscompares++; $display("FAIL reset_oob: got %b expected 0", a_oob); end
        vectors++; if (a_perr !== 1'b0) begin miscompares++; $display("FAIL reset_perr: got %b expected 0", a_perr); end
        vectors++; if (a_done !== 1'b0) begin miscompares++; $display("FAIL reset_init_done: got %b expected 0", a_done); end
        vectors++; if (a_gnt !== 1'b0) begin miscompares++; $display("FAIL reset_gnt: got %b expected 0", a_gnt); end
        a_rst = 1'b0;
        cycles = 0; saw_rv = 1'b0; saw_gnt = 1'b0;
        while (!a_done && cycles < 400) begin
            @(posedge clk); #1;
            cycles++;
            if (a_rvalid) saw_rv = 1'b1;
            if (a_gnt && !a_done) saw_gnt = 1'b1;
        end
        a_en = 1'b0;
        vectors++; if (cycles !== 256) begin miscompares++; $display("FAIL init_cycles: got %0d expected 256", cycles); end
        vectors++; if (saw_gnt !== 1'b0) begin miscompares++; $display("FAIL init_gnt: got %b expected 0", saw_gnt); end
        vectors++; if (saw_rv !== 1'b0) begin miscompares++; $display("FAIL init_rvalid: got %b expected 0", saw_rv); end
        a_en = 1'b1; a_we = 1'b0; a_addr = 8'h10;
        #1;
        vectors++; if (a_gnt !== 1'b1) begin miscompares++; $display("FAIL ready_gnt: got %b expected 1", a_gnt); end
        @(posedge clk); #1;
        a_en = 1'b0;
        vectors++; if (a_rvalid !== 1'b1) begin miscompares++; $display("FAIL clear_read_rvalid: got %b expected 1", a_rvalid); end
        vectors++; if (a_rdata !== 32'h0) begin miscompares++; $display("FAIL clear_read_data: got %h expected 00000000", a_rdata); end
    endtask

    task automatic test_byte_enable;
        a_issue(1'b1, 8'h05, 32'hDEADBEEF, 4'b1111);
        vectors++; if (a_rvalid !== 1'b0) begin miscompares++; $display("FAIL write_no_rvalid: got %b expected 0", a_rvalid); end
        a_issue(1'b1, 8'h05, 32'h00000055, 4'b0001);
        a_issue(1'b0, 8'h05, 32'h0, 4'b0000);
        vectors++; if (a_rvalid !== 1'b1) begin miscompares++; $display("FAIL be_read_rvalid: got %b expected 1", a_rvalid); end
        vectors++; if (a_rdata !== 32'hDEADBE55) begin miscompares++; $display("FAIL be_read_data: got %h expected DEADBE55", a_rdata); end
        @(posedge clk); #1;
        vectors++; if (a_rvalid !== 1'b0) begin miscompares++; $display("FAIL rvalid_pulse: got %b expected 0", a_rvalid); end
        vectors++; if (a_rdata !== 32'hDEADBE55) begin miscompares++; $display("FAIL rdata_hold: got %h expected DEADBE55", a_rdata); end
        a_issue(1'b1, 8'h05, 32'h12345678, 4'b0000);
        a_issue(1'b1, 8'h06, 32'hA5A5A5A5, 4'b1010);
        a_issue(1'b0, 8'h05, 32'h0, 4'b0000);
        vectors++; if (a_rdata !== 32'hDEADBE55) begin miscompares++; $display("FAIL be_zero_noop: got %h expected DEADBE55", a_rdata); end
        a_issue(1'b0, 8'h06, 32'h0, 4'b0000);
        vectors++; if (a_rdata !== 32'hA500A500) begin miscompares++; $display("FAIL be_sparse: got %h expected A500A500", a_rdata); end
    endtask

    task automatic test_parity;
        a_issue(1'b1, 8'h20, 32'h0F0F0F01, 4'b1111);
        a_issue(1'b0, 8'h20, 32'h0, 4'b0000);
        vectors++; if (a_rvalid !== 1'b1) begin miscompares++; $display("FAIL clean_read_rvalid: got %b expected 1", a_rvalid); end
        vectors++; if (a_perr !== 1'b0) begin miscompares++; $display("FAIL clean_read_perr: got %b expected 0", a_perr); end
`ifdef SP_RAM_PARITY_EN
        dut_a.r_mem[32][3] = ~dut_a.r_mem[32][3];
        a_issue(1'b0, 8'h20, 32'h0, 4'b0000);
        vectors++; if (a_rvalid !== 1'b1) begin miscompares++; $display("FAIL flip_read_rvalid: got %b expected 1", a_rvalid); end
        vectors++; if (a_perr !== 1'b1) begin miscompares++; $display("FAIL flip_read_perr: got %b expected 1", a_perr); end
        vectors++; if (a_rdata !== 32'h0F0F0F09) begin miscompares++; $display("FAIL flip_read_data: got %h expected 0F0F0F09", a_rdata); end
        a_issue(1'b1, 8'h20, 32'h0F0F0F01, 4'b0001);
        a_issue(1'b0, 8'h20, 32'h0, 4'b0000);
        vectors++; if (a_perr !== 1'b0) begin miscompares++; $display("FAIL rewrite_perr: got %b expected 0", a_perr); end
`endif
    endtask

    task automatic test_sweep_restart;
        int cycles;
        a_issue(1'b1, 8'h07, 32'hCAFEF00D, 4'b1111);
        a_rst = 1'b1;
        @(posedge clk); #1;
        vectors++; if (a_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata_clear: got %h expected 00000000", a_rdata); end
        vectors++; if (a_done !== 1'b0) begin miscompares++; $display("FAIL rst_done_drop: got %b expected 0", a_done); end
        a_rst = 1'b0;
        cycles = 0;
        while (!a_done && cycles < 400) begin
            @(posedge clk); #1;
            cycles++;
        end
        vectors++; if (cycles !== 256) begin miscompares++; $display("FAIL restart_cycles: got %0d expected 256", cycles); end
        a_issue(1'b0, 8'h07, 32'h0, 4'b0000);
        vectors++; if (a_rdata !== 32'h0) begin miscompares++; $display("FAIL restart_word7: got %h expected 00000000", a_rdata); end
        a_issue(1'b0, 8'h05, 32'h0, 4'b0000);
        vectors++; if ({a_rvalid, a_rdata} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL restart_word5: got %b/%h expected 1/00000000", a_rvalid, a_rdata); end
    endtask

    task automatic test_no_clear_init;
        int rv_n, rv_pos, oob_n, oob_pos, perr_n;
        logic [31:0] rd;
        b_rst = 1'b1; b_en = 1'b1; b_we = 1'b0; b_addr = 8'h01;
        @(posedge clk); #1;
        b_rst = 1'b0;
        vectors++; if ({b_done, b_gnt} !== 2'b00) begin miscompares++; $display("FAIL b_init_state: got %b expected 00", {b_done, b_gnt}); end
        @(posedge clk); #1;
        vectors++; if (b_done !== 1'b1) begin miscompares++; $display("FAIL b_ready_next: got %b expected 1", b_done); end
        b_en = 1'b0;
        b_observe(rv_n, rv_pos, oob_n, oob_pos, perr_n, rd);
        vectors++; if (rv_n !== 0) begin miscompares++; $display("FAIL b_init_not_queued: got %0d expected 0", rv_n); end
        b_issue(1'b1, 8'h01, 32'h11111111, 4'b1111);
        b_issue(1'b1, 8'h02, 32'h22222222, 4'b1111);
        b_issue(1'b1, 8'h03, 32'h33333333, 4'b1111);
        b_issue(1'b1, 8'hC7, 32'hC7C7C7C7, 4'b1111);
    endtask

    task automatic test_back_to_back;
        b_en = 1'b1; b_we = 1'b0; b_addr = 8'h01;
        @(posedge clk); #1;
        vectors++; if (b_rvalid !== 1'b0) begin miscompares++; $display("FAIL b2b_early1: got %b expected 0", b_rvalid); end
        b_addr = 8'h02;
        @(posedge clk); #1;
        vectors++; if (b_rvalid !== 1'b0) begin miscompares++; $display("FAIL b2b_early2: got %b expected 0", b_rvalid); end
        b_addr = 8'h03;
        @(posedge clk); #1;
        b_en = 1'b0;
        vectors++; if ({b_rvalid, b_rdata} !== {1'b1, 32'h11111111}) begin miscompares++; $display("FAIL b2b_first: got %b/%h expected 1/11111111", b_rvalid, b_rdata); end
        @(posedge clk); #1;
        vectors++; if ({b_rvalid, b_rdata} !== {1'b1, 32'h22222222}) begin miscompares++; $display("FAIL b2b_second: got %b/%h expected 1/22222222", b_rvalid, b_rdata); end
        @(posedge clk); #1;
        vectors++; if ({b_rvalid, b_rdata} !== {1'b1, 32'h33333333}) begin miscompares++; $display("FAIL b2b_third: got %b/%h expected 1/33333333", b_rvalid, b_rdata); end
        @(posedge clk); #1;
        vectors++; if ({b_rvalid, b_rdata} !== {1'b0, 32'h33333333}) begin miscompares++; $display("FAIL b2b_after: got %b/%h expected 0/33333333", b_rvalid, b_rdata); end
    endtask

    task automatic test_oob;
        int rv_n, rv_pos, oob_n, oob_pos, perr_n;
        logic [31:0] rd;
        b_issue(1'b1, 8'hC8, 32'hFFFFFFFF, 4'b1111);
        b_observe(rv_n, rv_pos, oob_n, oob_pos, perr_n, rd);
        vectors++; if ({oob_n, oob_pos} !== {32'd1, 32'd3}) begin miscompares++; $display("FAIL oob_write_pulse: got n=%0d pos=%0d expected n=1 pos=3", oob_n, oob_pos); end
        vectors++; if (rv_n !== 0) begin miscompares++; $display("FAIL oob_write_rvalid: got %0d expected 0", rv_n); end
        b_issue(1'b0, 8'hC8, 32'h0, 4'b0000);
        b_observe(rv_n, rv_pos, oob_n, oob_pos, perr_n, rd);
        vectors++; if ({rv_n, rv_pos} !== {32'd1, 32'd3}) begin miscompares++; $display("FAIL oob_read_rvalid: got n=%0d pos=%0d expected n=1 pos=3", rv_n, rv_pos); end
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL oob_read_data: got %h expected 00000000", rd); end
        vectors++; if ({oob_n, oob_pos} !== {32'd1, 32'd3}) begin miscompares++; $display("FAIL oob_read_pulse: got n=%0d pos=%0d expected n=1 pos=3", oob_n, oob_pos); end
        vectors++; if (perr_n !== 0) begin miscompares++; $display("FAIL oob_read_perr: got %0d expected 0", perr_n); end
        b_issue(1'b0, 8'hC7, 32'h0, 4'b0000);
        b_observe(rv_n, rv_pos, oob_n, oob_pos, perr_n, rd);
        vectors++; if ({rv_n, rv_pos} !== {32'd1, 32'd3}) begin miscompares++; $display("FAIL last_word_rvalid: got n=%0d pos=%0d expected n=1 pos=3", rv_n, rv_pos); end
        vectors++; if (rd !== 32'hC7C7C7C7) begin miscompares++; $display("FAIL last_word_data: got %h expected C7C7C7C7", rd); end
        vectors++; if (oob_n !== 0) begin miscompares++; $display("FAIL last_word_oob: got %0d expected 0", oob_n); end
    endtask

    task automatic test_reset_midop;
        int rv_n, rv_pos, oob_n, oob_pos, perr_n, gnt_n;
        logic [31:0] rd;
        b_issue(1'b0, 8'h01, 32'h0, 4'b0000);
        b_rst = 1'b1; b_en = 1'b1; b_we = 1'b0; b_addr = 8'h02;
        rv_n = 0; gnt_n = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (b_rvalid) rv_n++;
            if (b_gnt) gnt_n++;
        end
        b_rst = 1'b0;
        if (b_gnt) gnt_n++;
        if (b_rvalid) rv_n++;
        vectors++; if (rv_n !== 0) begin miscompares++; $display("FAIL midop_rvalid: got %0d expected 0", rv_n); end
        vectors++; if (gnt_n !== 0) begin miscompares++; $display("FAIL midop_gnt: got %0d expected 0", gnt_n); end
        @(posedge clk); #1;
        vectors++; if ({b_done, b_gnt} !== 2'b11) begin miscompares++; $display("FAIL midop_ready: got %b expected 11", {b_done, b_gnt}); end
        b_en = 1'b0;
        b_observe(rv_n, rv_pos, oob_n, oob_pos, perr_n, rd);
        vectors++; if (rv_n !== 0) begin miscompares++; $display("FAIL midop_no_late_rvalid: got %0d expected 0", rv_n); end
    endtask

    initial begin
        a_rst = 1'b1; a_en = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
        b_rst = 1'b1; b_en = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
        test_reset;
        test_byte_enable;
        test_parity;
        test_sweep_restart;
        test_no_clear_init;
        test_back_to_back;
        test_oob;
        test_reset_midop;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_sp_ram_model
`default_nettype wire
